// File: rtl/cache_init_ctrl.sv
// Line-walk sequencer: invalidates every line after reset, then re-walks in flush mode on request.
// One entry per cycle; stalls while any bank holds cmd_ready low. Way walking: CACHE_INIT_WAY_WALK_EN.
module cache_init_ctrl #(
   parameter int CACHE_SIZE = 16384,
   parameter int LINE_SIZE  = 64,
   parameter int NUM_BANKS  = 1,
   parameter int NUM_WAYS   = 1,
   localparam int LINES     = CACHE_SIZE / (LINE_SIZE * NUM_BANKS * NUM_WAYS),
   localparam int LSB       = (LINES > 1) ? $clog2(LINES) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush_req_valid,
   output logic                 flush_req_ready,
   output logic                 flush_rsp_valid,
   input  logic                 flush_rsp_ready,
   output logic                 cmd_valid,
   input  logic [NUM_BANKS-1:0] cmd_ready,
   output logic [LSB-1:0]       cmd_addr,
   output logic [NUM_WAYS-1:0]  cmd_way,
   output logic                 cmd_flush,
   output logic                 init_done,
   output logic                 busy
);

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_FLUSH, ST_RESP} state_t;

   localparam logic [LSB-1:0] LAST_LINE = LSB'(LINES - 1);
   localparam logic [LSB-1:0] LINE_ONE  = LSB'(1);

   state_t         state_q, state_d;
   logic [LSB-1:0] line_q, line_d;
   logic           init_done_q, init_done_d;
   logic           sweep_active;
   logic           fire;
   logic           line_step;
   logic           sweep_last;
   logic           ctr_clr;

   // Outputs decode straight from registered state, so cmd_ready never reaches cmd_valid.
   assign sweep_active = (state_q == ST_INIT) || (state_q == ST_FLUSH);
   assign fire         = sweep_active && (&cmd_ready);
   assign cmd_valid    = sweep_active;
   assign busy         = sweep_active;
   assign cmd_flush    = (state_q == ST_FLUSH);
   assign cmd_addr     = line_q;
   assign init_done    = init_done_q;

`ifdef CACHE_INIT_WAY_WALK_EN
   localparam int             WSB      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
   localparam logic [WSB-1:0] LAST_WAY = WSB'(NUM_WAYS - 1);
   localparam logic [WSB-1:0] WAY_ONE  = WSB'(1);

   logic [WSB-1:0] way_q, way_d;

   assign line_step = (way_q == LAST_WAY);
   assign cmd_way   = NUM_WAYS'(1) << way_q;

   always_comb begin
      way_d = way_q;
      if (ctr_clr) begin
         way_d = '0;
      end else if (fire) begin
         way_d = line_step ? '0 : way_q + WAY_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         way_q <= '0;
      end else begin
         way_q <= way_d;
      end
   end
`else
   assign line_step = 1'b1;
   assign cmd_way   = '1;
`endif

   assign sweep_last = (line_q == LAST_LINE) && line_step;

   always_comb begin
      state_d         = state_q;
      init_done_d     = init_done_q;
      ctr_clr         = 1'b0;
      flush_req_ready = 1'b0;
      flush_rsp_valid = 1'b0;
      case (state_q)
         ST_INIT: begin
            if (fire && sweep_last) begin
               state_d     = ST_IDLE;
               init_done_d = 1'b1;
            end
         end
         ST_IDLE: begin
            flush_req_ready = 1'b1;
            if (flush_req_valid) begin
               state_d = ST_FLUSH;
               ctr_clr = 1'b1;
            end
         end
         ST_FLUSH: begin
            if (fire && sweep_last) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            flush_rsp_valid = 1'b1;
            if (flush_rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   // Line counter wraps only at the end of a sweep, leaving it at 0 for the next one.
   always_comb begin
      line_d = line_q;
      if (ctr_clr) begin
         line_d = '0;
      end else if (fire) begin
         if (sweep_last) begin
            line_d = '0;
         end else if (line_step) begin
            line_d = line_q + LINE_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_INIT;
         line_q      <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         line_q      <= line_d;
         init_done_q <= init_done_d;
      end
   end

endmodule

// File: tb/tb_cache_init_ctrl.sv
// Scoreboard bench for cache_init_ctrl: expected commands/responses queued by stimulus, popped by monitor.
module tb_cache_init_ctrl;

   localparam int CACHE_SIZE = 1024;
   localparam int LINE_SIZE  = 16;
   localparam int NUM_BANKS  = 2;
   localparam int NUM_WAYS   = 2;
   localparam int LINES      = 16;
`ifdef CACHE_INIT_WAY_WALK_EN
   localparam int N_SWEEP    = LINES * NUM_WAYS;
`else
   localparam int N_SWEEP    = LINES;
`endif
   localparam int LIMIT      = 300;

   typedef struct packed {
      logic [3:0] addr;
      logic [1:0] way;
      logic       flush;
   } cmd_t;

   logic       clk;
   logic       reset;
   logic       flush_req_valid;
   logic       flush_req_ready;
   logic       flush_rsp_valid;
   logic       flush_rsp_ready;
   logic       cmd_valid;
   logic [1:0] cmd_ready;
   logic [3:0] cmd_addr;
   logic [1:0] cmd_way;
   logic       cmd_flush;
   logic       init_done;
   logic       busy;

   cmd_t exp_q[$];
   int   rsp_exp;
   int   n_checks;
   int   n_fails;
   int   fire_cnt;
   int   rsp_cnt;

   cache_init_ctrl #(
      .CACHE_SIZE(CACHE_SIZE),
      .LINE_SIZE (LINE_SIZE),
      .NUM_BANKS (NUM_BANKS),
      .NUM_WAYS  (NUM_WAYS)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .flush_req_valid(flush_req_valid),
      .flush_req_ready(flush_req_ready),
      .flush_rsp_valid(flush_rsp_valid),
      .flush_rsp_ready(flush_rsp_ready),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_addr       (cmd_addr),
      .cmd_way        (cmd_way),
      .cmd_flush      (cmd_flush),
      .init_done      (init_done),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_sweep(input logic fl);
      cmd_t e;
      for (int l = 0; l < LINES; l++) begin
`ifdef CACHE_INIT_WAY_WALK_EN
         for (int w = 0; w < NUM_WAYS; w++) begin
            e.addr  = 4'(l);
            e.way   = 2'(1 << w);
            e.flush = fl;
            exp_q.push_back(e);
         end
`else
         e.addr  = 4'(l);
         e.way   = 2'b11;
         e.flush = fl;
         exp_q.push_back(e);
`endif
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: samples on the falling edge, pops an expectation for every fire / response accept.
   initial begin
      cmd_t got;
      cmd_t want;
      cmd_t prev;
      logic prev_pending;
      logic fire;
      prev_pending = 1'b0;
      prev = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_pending = 1'b0;
         end else begin
            got = '{addr: cmd_addr, way: cmd_way, flush: cmd_flush};
            if (prev_pending) begin
               check("cmd_stable", {cmd_valid, 24'd0, got}, {1'b1, 24'd0, prev});
            end
            fire = cmd_valid && (&cmd_ready);
            if (fire) begin
               fire_cnt++;
               if (exp_q.size() == 0) begin
                  check("cmd_unexpected", 32'(got), 32'hFFFF);
               end else begin
                  want = exp_q.pop_front();
                  check("cmd_fire", 32'(got), 32'(want));
               end
            end
            prev_pending = cmd_valid && !fire;
            prev = got;
            if (flush_rsp_valid && flush_rsp_ready) begin
               rsp_cnt++;
               check("rsp_expected", 32'(rsp_exp > 0), 32'd1);
               if (rsp_exp > 0) rsp_exp--;
            end
         end
      end
   end

   initial begin
      int n;
      int rdy_in_init;
      int base;
      n_checks = 0;
      n_fails  = 0;
      fire_cnt = 0;
      rsp_cnt  = 0;
      rsp_exp  = 0;
      rdy_in_init = 0;
      reset = 1'b1;
      cmd_ready = 2'b11;
      flush_req_valid = 1'b1;
      flush_rsp_ready = 1'b0;
      push_sweep(1'b0);
      push_sweep(1'b1);

      tick();
      tick();
      check("rst_cmd_valid", 32'(cmd_valid), 32'd1);
      check("rst_cmd_addr", 32'(cmd_addr), 32'd0);
      check("rst_cmd_flush", 32'(cmd_flush), 32'd0);
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_init_done", 32'(init_done), 32'd0);
      check("rst_req_ready", 32'(flush_req_ready), 32'd0);
      check("rst_rsp_valid", 32'(flush_rsp_valid), 32'd0);
      reset = 1'b0;

      // Stall one bank for three cycles when line 5 is presented.
      for (n = 0; n < LIMIT; n++) begin
         tick();
         if (flush_req_ready) rdy_in_init++;
         if (cmd_addr == 4'd5) break;
      end
      check("reach_addr5", 32'(n < LIMIT), 32'd1);
      cmd_ready = 2'b01;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (flush_req_ready) rdy_in_init++;
         check("stall_addr", {27'd0, cmd_valid, cmd_addr}, {27'd0, 1'b1, 4'd5});
      end
      cmd_ready = 2'b11;

      for (n = 0; n < LIMIT; n++) begin
         if (!cmd_valid) break;
         if (flush_req_ready) rdy_in_init++;
         check("init_done_early", 32'(init_done), 32'd0);
         tick();
      end
      check("init_end_wait", 32'(n < LIMIT), 32'd1);
      check("init_fire_count", 32'(fire_cnt), 32'(N_SWEEP));
      check("init_done_set", 32'(init_done), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_req_ready", 32'(flush_req_ready), 32'd1);
      check("req_ready_in_init", 32'(rdy_in_init), 32'd0);

      // Held request is taken in the first idle cycle.
      tick();
      flush_req_valid = 1'b0;
      check("flush_start", {29'd0, cmd_valid, cmd_flush, busy}, {29'd0, 3'b111});
      check("flush_start_addr", 32'(cmd_addr), 32'd0);

      for (n = 0; n < LIMIT; n++) begin
         if (!cmd_valid) break;
         tick();
      end
      check("flush_end_wait", 32'(n < LIMIT), 32'd1);
      check("flush_fire_count", 32'(fire_cnt), 32'(2 * N_SWEEP));
      check("rsp_valid_rise", 32'(flush_rsp_valid), 32'd1);
      check("resp_busy", 32'(busy), 32'd0);
      rsp_exp = 1;
      flush_req_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rsp_hold", 32'(flush_rsp_valid), 32'd1);
         check("resp_req_ready", 32'(flush_req_ready), 32'd0);
      end
      // Response accept and a new request together: request goes in the next cycle.
      flush_rsp_ready = 1'b1;
      push_sweep(1'b1);
      tick();
      check("rsp_cleared", 32'(flush_rsp_valid), 32'd0);
      check("rsp_count", 32'(rsp_cnt), 32'd1);
      check("idle2_ready", {30'd0, flush_req_ready, cmd_valid}, {30'd0, 2'b10});
      tick();
      flush_req_valid = 1'b0;
      check("flush2_start", {30'd0, cmd_valid, cmd_flush}, {30'd0, 2'b11});

      for (n = 0; n < LIMIT; n++) begin
         if (cmd_addr == 4'd9) break;
         tick();
      end
      check("reach_flush_addr9", 32'(n < LIMIT), 32'd1);
      reset = 1'b1;
      exp_q.delete();
      push_sweep(1'b0);
      tick();
      check("rst2_addr", 32'(cmd_addr), 32'd0);
      check("rst2_valid_flush", {30'd0, cmd_valid, cmd_flush}, {30'd0, 2'b10});
      check("rst2_init_done", 32'(init_done), 32'd0);
      check("rst2_rsp_valid", 32'(flush_rsp_valid), 32'd0);
      reset = 1'b0;
      base = fire_cnt;

      for (n = 0; n < LIMIT; n++) begin
         if (init_done) break;
         check("rst2_no_rsp", 32'(flush_rsp_valid), 32'd0);
         tick();
      end
      check("reinit_wait", 32'(n < LIMIT), 32'd1);
      check("reinit_fire_count", 32'(fire_cnt - base), 32'(N_SWEEP));
      for (int i = 0; i < 5; i++) tick();
      check("no_late_rsp", 32'(rsp_cnt), 32'd1);
      check("final_idle", {30'd0, flush_rsp_valid, cmd_valid}, 32'd0);
      check("exp_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule
